// File: rtl/scan_enc_pkg.sv
// Shared definitions for the one-hot scan encoder.
//   state_t     : FSM state encoding (IDLE waits for a vector, EMIT streams indices)
//   N_DEF       : default request-vector width
//   IDX_W_DEF   : default index width, $clog2(N_DEF)
package scan_enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int N_DEF     = 8;
  localparam int IDX_W_DEF = $clog2(N_DEF);

endpackage

// File: rtl/priority_encoder_8x3.sv
// Combinational priority encoder: lowest set bit wins.
// Ports:
//   vec  in  N      vector to scan
//   idx  out IDX_W  index of the lowest set bit (0 when vec is all-zero)
//   any  out 1      at least one bit of vec is set
module priority_encoder_8x3
  import scan_enc_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scanning from the top down lets the lowest set bit overwrite the rest.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/onehot_scan_encoder.sv
// Sequential N-to-IDX_W encoder. Accepts a request vector over a valid/ready
// handshake, then emits the index of every set bit, lowest first, one beat
// per accepted output handshake. An all-zero vector yields a single beat
// flagged with out_none.
// Ports:
//   clk        in  1      rising-edge clock
//   rst_n      in  1      synchronous active-low reset
//   in_valid   in  1      in_vec is presented
//   in_ready   out 1      block can accept a vector (IDLE)
//   in_vec     in  N      request vector
//   out_valid  out 1      beat is presented (EMIT)
//   out_ready  in  1      consumer accepts the current beat
//   out_idx    out IDX_W  index of the lowest pending set bit
//   out_none   out 1      accepted vector was all-zero
//   out_last   out 1      current beat is the final one for this vector
module onehot_scan_encoder
  import scan_enc_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_none,
  output logic             out_last
);

  localparam logic [N-1:0] ONE = N'(1);

  state_t           state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             at_most_one;

  priority_encoder_8x3 #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_prio (
    .vec (pending_q),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Clearing the lowest set bit leaves zero iff at most one bit was set;
  // this also covers the all-zero vector, which is its own last beat.
  assign at_most_one = ((pending_q & (pending_q - ONE)) == '0);

  // Outputs depend on registered state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_none  = 1'b0;
    out_last  = 1'b0;
    if (state_q == IDLE) begin
      in_ready = 1'b1;
    end else begin
      out_valid = 1'b1;
      out_idx   = enc_idx;
      out_none  = ~enc_any;
      out_last  = at_most_one;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = EMIT;
          pending_d = in_vec;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pending_d = pending_q & ~(ONE << enc_idx);
          if (at_most_one) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: doc/onehot_scan_encoder.md
# onehot_scan_encoder

Sequential 8-to-3 encoder: the inverse direction of the 3x8 decoder used by the decoder-based full adder.
- Accepts an 8-bit request vector through a valid/ready handshake.
- Emits the 3-bit index of every set bit, one per beat, lowest index first, then returns to idle.
- Sits between bit-vector producers (decoder outputs, request masks) and logic that consumes binary indices.

## Interface
Parameters:
- N, 8, width of the request vector; power of two, ≥ 2.
- IDX_W, $clog2(N), width of the emitted index.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- in_valid  input  1  in_vec is presented.
- in_ready  output  1  block can accept a vector.
- in_vec  input  N  request vector; bit i set means index i is to be emitted.
- out_valid  output  1  out_idx, out_none and out_last are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_idx  output  IDX_W  index of the lowest pending set bit.
- out_none  output  1  accepted vector was all-zero.
- out_last  output  1  current beat is the final beat for this vector.

## Operation
- States:
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1.
- IDLE → EMIT on in_valid & in_ready. The pending register loads in_vec.
- In EMIT:
  - out_idx = index of the lowest set bit of pending.
  - out_last = 1 when pending has at most one bit set.
- out_none:
  - If the accepted vector is zero, EMIT presents exactly one beat: out_none=1, out_idx=0, out_last=1.
  - out_none=0 on every other beat.
- On out_valid & out_ready in EMIT:
  - Clear the bit at out_idx in pending.
  - If out_last: → IDLE.
  - Otherwise stay in EMIT; the next-lowest bit appears the following cycle.
- out_valid=0 in IDLE. In that state out_idx, out_none and out_last are driven 0.
- out_ready low: out_idx, out_none, out_last and pending hold stable. out_valid stays high; it never drops without a handshake.
- No new vector is accepted until the final beat of the current vector completes. in_vec is ignored while in_ready=0.
- in_valid may stay high across vectors. The next vector is accepted the cycle the block is back in IDLE.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE, pending=0.
- Outputs after reset: in_ready=1, out_valid=0, out_idx=0, out_none=0, out_last=0.
- Latency: vector accepted at edge k → first beat valid in cycle k+1.
- Throughput:
  - One index per cycle when out_ready is held high.
  - A vector with p set bits (p≥1) occupies p beats plus the accept cycle.
  - The next accept is at the earliest 1 cycle after the final beat.
- Boundaries:
  - All bits set: emits 0..N-1 in order; out_last only on index N-1.
  - Only bit N-1 set: one beat, out_idx=N-1, out_last=1.
  - Reset mid-EMIT: the vector is discarded, with no further beats. in_ready=1 the cycle after reset deasserts.
- Outputs are combinational from the state and pending registers only. There is no combinational path from in_valid or out_ready to any output.

## Structure
- Shared package `scan_enc_pkg`:
  - state typedef {IDLE, EMIT}.
  - Default N / IDX_W constants.
- One sub-module, `priority_encoder_8x3` (parameterised by N):
  - Combinational; takes a vector and returns the lowest set index plus an any-set flag.
  - Instantiated once, on the pending register.
- Top level holds the FSM, the pending register, bit-clear logic and the out_last detect (pending & (pending−1) == 0).

## Test plan
- Reset, then in_vec=8'b1010_0110 with out_ready=1 → out_idx 1,2,5,7 on consecutive cycles starting 1 cycle after accept; out_last only with 7; in_ready=1 the cycle after.
- in_vec=8'h00 → single beat: out_none=1, out_idx=0, out_last=1; then IDLE.
- in_vec=8'hFF, out_ready toggled 1,0,0,1,… → indices 0..7 in order, none skipped or repeated; outputs stable while out_ready=0.
- in_vec=8'h80 → one beat: out_idx=7, out_last=1. Then, with in_valid held, in_vec=8'h01 → accepted the cycle IDLE is reached; out_idx=0 beat follows.
- in_vec=8'h3C, rst_n pulsed low after the index-2 beat → no further beats; out_valid=0, in_ready=1 after reset.
- in_vec changed while in_ready=0 → change ignored; emitted indices match the originally accepted vector.
